// File: rtl/cpld_display_pkg.sv
// Shared definitions for the CPLD display serial link: transmitter FSM
// states, default geometry and the largest value the BCD digit chain can show.
package cpld_display_pkg;

  localparam int DEF_WIDTH  = 10;
  localparam int DEF_DIV    = 4;
  localparam int DEF_DIGITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

  // Largest value representable on a chain of 'digits' BCD digits (10**digits - 1).
  function automatic int bcd_max(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/serial_bin_tx_if.sv
// Host-to-display link of serial_bin_tx: parallel valid/ready request side
// plus the serial sclk/dout/sclr lines and the done strobe.
interface serial_bin_tx_if
  import cpld_display_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             sclk;
  logic             dout;
  logic             sclr;
  logic             done;

  // Host side: offers a value and watches the serial frame.
  modport master (
    output data, valid,
    input  ready, sclk, dout, sclr, done
  );

  // Transmitter side.
  modport slave (
    input  data, valid,
    output ready, sclk, dout, sclr, done
  );

endinterface

// File: rtl/sclk_gen.sv
// Bit-period divider for serial_bin_tx. A period is 2*DIV clk cycles:
// DIV cycles with sclk low followed by DIV cycles with sclk high (high half
// only when sclk_en is set). half_end/period_end flag the last cycle of each
// half. The count is cleared by the FSM on accept so frames start aligned.
module sclk_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic sclk_en,
  output logic sclk,
  output logic half_end,
  output logic period_end
);

  localparam int CNTW = (DIV > 0) ? $clog2(2 * DIV) : 1;

  logic [CNTW-1:0] cnt;

  assign half_end   = run && (cnt == CNTW'(DIV - 1));
  assign period_end = run && (cnt == CNTW'(2 * DIV - 1));

  // Period counter and registered sclk level.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (run) begin
      cnt <= period_end ? '0 : cnt + CNTW'(1);
      if (period_end)
        sclk <= 1'b0;
      else if (half_end && sclk_en)
        sclk <= 1'b1;
    end else begin
      cnt  <= '0;
      sclk <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_bin_tx.sv
// Parallel-to-serial transmitter feeding the display's double-dabble BCD
// chain. Per frame: 2*DIV cycles of sclr, then WIDTH bits MSB-first, one per
// sclk period, then a one-cycle done pulse. All outputs are registered.
// Build option: SERIAL_BIN_TX_SATURATE_EN clamps accepted values above
// 10**DIGITS-1 to that maximum so the display never wraps.
module serial_bin_tx
  import cpld_display_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIV    = DEF_DIV,
  parameter int DIGITS = DEF_DIGITS
) (
  input logic            clk,
  input logic            rst,
  serial_bin_tx_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Reject geometries the frame timing cannot express.
  if (WIDTH < 1) begin : g_bad_width
    $error("serial_bin_tx: WIDTH must be >= 1");
  end
  if (DIV < 1) begin : g_bad_div
    $error("serial_bin_tx: DIV must be >= 1");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("serial_bin_tx: DIGITS must be >= 1");
  end

  tx_state_e        state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shl;
  logic [WIDTH-1:0] load_val;
  logic [CW-1:0]    bitcnt;
  logic             ready_q;
  logic             sclr_q;
  logic             dout_q;
  logic             done_q;
  logic             accept;
  logic             run;
  logic             half_end;
  logic             period_end;
  logic             sclk_w;

  assign accept = (state == ST_IDLE) && ready_q && bus.valid;
  assign run    = (state == ST_CLR) || (state == ST_SHIFT);
  assign sr_shl = sr << 1;

  // Value captured on accept, optionally clamped to the display maximum.
  always_comb begin
    load_val = bus.data;
`ifdef SERIAL_BIN_TX_SATURATE_EN
    if (64'(bus.data) > 64'(bcd_max(DIGITS)))
      load_val = WIDTH'(bcd_max(DIGITS));
`endif
  end

  sclk_gen #(
    .DIV(DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .run       (run),
    .sclk_en   (state == ST_SHIFT),
    .sclk      (sclk_w),
    .half_end  (half_end),
    .period_end(period_end)
  );

  // Frame sequencer: state, shift register, bit counter and registered outputs.
  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which keeps dout tied to the sr contents of the same period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bitcnt  <= '0;
      ready_q <= 1'b1;
      sclr_q  <= 1'b0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          dout_q <= 1'b0;
          if (accept) begin
            sr      <= load_val;
            ready_q <= 1'b0;
            sclr_q  <= 1'b1;
            state   <= ST_CLR;
          end
        end
        ST_CLR: begin
          if (period_end) begin
            sclr_q <= 1'b0;
            bitcnt <= CW'(WIDTH - 1);
            dout_q <= sr[WIDTH-1];
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (period_end) begin
            if (bitcnt == '0) begin
              dout_q <= 1'b0;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              sr     <= sr_shl;
              bitcnt <= bitcnt - CW'(1);
              dout_q <= sr_shl[WIDTH-1];
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.sclk  = sclk_w;
  assign bus.dout  = dout_q;
  assign bus.sclr  = sclr_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_bin_tx.sv
// Self-checking bench for serial_bin_tx: every cycle of each frame is compared
// against a waveform computed from the frame timing rules, and the received
// bits are decoded with a double-dabble digit model.
module tb_serial_bin_tx;

  localparam int W = 10;
  localparam int D = 4;
  localparam int T = 2 * D * (W + 1) + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_bin_tx_if #(.WIDTH(W)) bus ();
  serial_bin_tx_if #(.WIDTH(1)) bus1 ();

  serial_bin_tx #(.WIDTH(W), .DIV(D), .DIGITS(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  serial_bin_tx #(.WIDTH(1), .DIV(1), .DIGITS(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Value the receiver should see for a requested value.
  function automatic int expect_tx(input int v);
`ifdef SERIAL_BIN_TX_SATURATE_EN
    return (v > 999) ? 999 : v;
`else
    return v;
`endif
  endfunction

  // Expected {ready,sclk,dout,sclr,done} k cycles after the accept edge.
  function automatic int exp_vec(input int k, input int val, input int w, input int d);
    int j, i, ph;
    if (k >= 1 && k <= 2 * d) return 5'b00010;
    if (k > 2 * d && k <= 2 * d + 2 * d * w) begin
      j  = k - 2 * d - 1;
      i  = j / (2 * d);
      ph = j % (2 * d);
      return ((ph >= d) ? 8 : 0) + (((val >> (w - 1 - i)) & 1) * 4);
    end
    if (k == 2 * d * (w + 1) + 1) return 5'b00001;
    return 5'b10000;
  endfunction

  // Receiver model: three BCD digits loaded by shift-add-3, MSB first.
  function automatic int dabble(input int v, input int nbits);
    int h, t, o, b;
    h = 0; t = 0; o = 0;
    for (int i = nbits - 1; i >= 0; i--) begin
      b = (v >> i) & 1;
      if (h >= 5) h += 3;
      if (t >= 5) t += 3;
      if (o >= 5) o += 3;
      h = ((h << 1) | (t >> 3)) & 15;
      t = ((t << 1) | (o >> 3)) & 15;
      o = ((o << 1) | b) & 15;
    end
    return (h << 8) | (t << 4) | o;
  endfunction

  function automatic int digits_of(input int v);
    int m;
    m = v % 1000;
    return ((m / 100) << 8) | (((m / 10) % 10) << 4) | (m % 10);
  endfunction

  function automatic int outs();
    return int'({bus.ready, bus.sclk, bus.dout, bus.sclr, bus.done});
  endfunction

  // One frame on the default instance; called at a negedge with ready high.
  task automatic send(input int val, input bit keep_valid, input int busy_data);
    int   ev, bits, nrise, nsclr;
    logic prev_sclk;
    ev = expect_tx(val);
    bits = 0; nrise = 0; nsclr = 0; prev_sclk = 1'b0;
    bus.data  = W'(val);
    bus.valid = 1'b1;
    check($sformatf("ready_before_%0d", val), int'(bus.ready), 1);
    @(posedge clk);
    for (int k = 1; k <= T + 1; k++) begin
      @(negedge clk);
      if (k == 1 && !keep_valid) bus.valid = 1'b0;
      if (busy_data >= 0 && k == 30) begin
        bus.data  = W'(busy_data);
        bus.valid = 1'b1;
      end
      if (busy_data >= 0 && k == 60) bus.valid = 1'b0;
      check($sformatf("v%0d_cyc%0d", val, k), outs(), exp_vec(k, ev, W, D));
      if (bus.sclr) nsclr++;
      if (bus.sclk && !prev_sclk) begin
        bits = bits * 2 + int'(bus.dout);
        nrise++;
      end
      prev_sclk = bus.sclk;
    end
    check($sformatf("v%0d_sclr_cycles", val), nsclr, 2 * D);
    check($sformatf("v%0d_rises", val), nrise, W);
    check($sformatf("v%0d_bits", val), bits, ev);
    check($sformatf("v%0d_digits", val), dabble(bits, W), digits_of(ev));
  endtask

  initial begin
    int v, nbad, bits1;
    rst       = 1'b1;
    bus.data  = '0;
    bus.valid = 1'b0;
    bus1.data = 1'b0;
    bus1.valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_outs", outs(), 5'b10000);
    check("reset_outs_corner",
          int'({bus1.ready, bus1.sclk, bus1.dout, bus1.sclr, bus1.done}), 5'b10000);

    // Single frame of 637, then back-to-back 0 and 999.
    send(637, 1'b0, -1);
    send(0, 1'b1, -1);
    send(999, 1'b0, -1);

    // Busy request mid-SHIFT must be ignored and start no frame.
    send(637, 1'b0, 5);
    nbad = 0;
    repeat (20) begin
      @(negedge clk);
      if (outs() != 5'b10000) nbad++;
    end
    check("no_extra_frame", nbad, 0);

    // Above the display range.
    send(1023, 1'b0, -1);

    // Random values with random idle gaps.
    repeat (6) begin
      v = int'($urandom_range(0, 1023));
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
      send(v, 1'b0, -1);
    end

    // Reset during SHIFT aborts the frame without done.
    bus.data  = W'(637);
    bus.valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_frame", outs(), 5'b10000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset", outs(), 5'b10000);
    nbad = 0;
    repeat (T + 10) begin
      @(negedge clk);
      if (bus.done || bus.sclr || bus.sclk) nbad++;
    end
    check("no_done_after_abort", nbad, 0);

    // DIV=1, WIDTH=1 corner.
    bus1.data  = 1'b1;
    bus1.valid = 1'b1;
    bits1 = 0;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus1.valid = 1'b0;
      check($sformatf("corner_cyc%0d", k),
            int'({bus1.ready, bus1.sclk, bus1.dout, bus1.sclr, bus1.done}),
            exp_vec(k, 1, 1, 1));
      if (bus1.sclk) bits1 = bits1 * 2 + int'(bus1.dout) + 16;
    end
    check("corner_one_rise_bit1", bits1, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
